// File: rtl/cfg_write_arbiter.sv
// Two-requester arbiter for the latched config write port.
// Sequences setup/strobe/hold timing and returns ack/err.
module cfg_write_arbiter #(
  parameter int STROBE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int MAX_SPI_STREAK = 4
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic       spi_req,
  input  logic [7:0] spi_addr,
  input  logic [7:0] spi_data,
  output logic       spi_ack,
  output logic       spi_err,
  input  logic       int_req,
  input  logic [7:0] int_addr,
  input  logic [7:0] int_data,
  output logic       int_ack,
  output logic       int_err,
  output logic [7:0] wr_data,
  output logic [7:0] latch_strobe,
  output logic       busy,
  output logic       last_grant
);

  if (STROBE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      MAX_SPI_STREAK < 1) begin : g_bad_param
    $error("cfg_write_arbiter: parameters must be >= 1");
  end

  localparam int CMAX = (STROBE_CYCLES > HOLD_CYCLES) ?
                        STROBE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = $clog2(MAX_SPI_STREAK + 1);

  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [SW-1:0] S_MAX  = SW'(MAX_SPI_STREAK);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    strobe_q, strobe_d;
  logic          spi_ack_q, spi_ack_d;
  logic          spi_err_q, spi_err_d;
  logic          int_ack_q, int_ack_d;
  logic          int_err_q, int_err_d;
  logic          busy_q, busy_d;
  logic          last_grant_q, last_grant_d;

  logic          grant_int;
  logic          ack_d;
  logic          err_d;
  logic [7:0]    win_addr;
  logic [7:0]    win_data;
  logic [7:0]    win_sel;

  // Latch address to one-hot strobe; zero means no writable latch.
  function automatic logic [7:0] decode(input logic [7:0] a);
    logic [7:0] oh;
    oh = 8'h00;
    case (a)
      8'd1:    oh = 8'b0000_0001;
      8'd2:    oh = 8'b0000_0010;
      8'd3:    oh = 8'b0000_0100;
      8'd60:   oh = 8'b0000_1000;
      8'd61:   oh = 8'b0001_0000;
      8'd62:   oh = 8'b0010_0000;
      8'd64:   oh = 8'b0100_0000;
      8'd65:   oh = 8'b1000_0000;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

  // Arbitration winner and its request fields.
  always_comb begin
    grant_int = int_req &&
                (!spi_req || streak_q == S_MAX);
    win_addr  = grant_int ? int_addr : spi_addr;
    win_data  = grant_int ? int_data : spi_data;
    win_sel   = decode(win_addr);
  end

  // Next state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    sel_d        = sel_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    strobe_d     = 8'h00;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spi_req || int_req) begin
          last_grant_d = grant_int;
          sel_d        = win_sel;
          if (grant_int) begin
            streak_d = '0;
          end else if (int_req) begin
            streak_d = (streak_q == S_MAX) ?
                       streak_q : streak_q + S_ONE;
          end else begin
            streak_d = '0;
          end
          if (|win_sel) begin
            state_d   = SETUP;
            wr_data_d = win_data;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d  = STROBE;
        strobe_d = sel_q;
        cnt_d    = S_LAST;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = H_LAST;
          ack_d   = (HOLD_CYCLES == 1);
        end else begin
          strobe_d = sel_q;
          cnt_d    = cnt_q - C_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - C_ONE;
          ack_d = (cnt_q == C_ONE);
        end
      end
      RESP: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    spi_ack_d = ack_d & ~last_grant_d;
    int_ack_d = ack_d &  last_grant_d;
    spi_err_d = err_d & ~last_grant_d;
    int_err_d = err_d &  last_grant_d;
    busy_d    = (state_d != IDLE);
  end

  // State and output registers, cleared at once by reset.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      streak_q     <= '0;
      sel_q        <= 8'h00;
      wr_data_q    <= 8'h00;
      strobe_q     <= 8'h00;
      spi_ack_q    <= 1'b0;
      spi_err_q    <= 1'b0;
      int_ack_q    <= 1'b0;
      int_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      sel_q        <= sel_d;
      wr_data_q    <= wr_data_d;
      strobe_q     <= strobe_d;
      spi_ack_q    <= spi_ack_d;
      spi_err_q    <= spi_err_d;
      int_ack_q    <= int_ack_d;
      int_err_q    <= int_err_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_data      = wr_data_q;
  assign latch_strobe = strobe_q;
  assign spi_ack      = spi_ack_q;
  assign spi_err      = spi_err_q;
  assign int_ack      = int_ack_q;
  assign int_err      = int_err_q;
  assign busy         = busy_q;
  assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: directed and random writes
// checked cycle by cycle against a transaction-level model.
module tb_cfg_write_arbiter;

  logic       iclk = 1'b0;
  logic       rst;
  logic       spi_req, int_req;
  logic [7:0] spi_addr, spi_data, int_addr, int_data;

  logic       a_sack, a_serr, a_iack, a_ierr, a_busy, a_lg;
  logic [7:0] a_wr, a_stb;
  logic       b_sack, b_serr, b_iack, b_ierr, b_busy, b_lg;
  logic [7:0] b_wr, b_stb;

  logic       o_sack, o_serr, o_iack, o_ierr, o_busy, o_lg;
  logic [7:0] o_wr, o_stb;

  bit         use2 = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         streak = 0;
  logic [7:0] last_wr = 8'h00;
  localparam int MAXS = 4;
  int         valid_addrs [8] = '{1, 2, 3, 60, 61, 62, 64, 65};

  cfg_write_arbiter dut (
    .iclk(iclk), .rst(rst),
    .spi_req(spi_req), .spi_addr(spi_addr),
    .spi_data(spi_data), .spi_ack(a_sack),
    .spi_err(a_serr), .int_req(int_req),
    .int_addr(int_addr), .int_data(int_data),
    .int_ack(a_iack), .int_err(a_ierr),
    .wr_data(a_wr), .latch_strobe(a_stb),
    .busy(a_busy), .last_grant(a_lg)
  );

  cfg_write_arbiter #(
    .STROBE_CYCLES(1), .HOLD_CYCLES(3), .MAX_SPI_STREAK(4)
  ) dut2 (
    .iclk(iclk), .rst(rst),
    .spi_req(spi_req), .spi_addr(spi_addr),
    .spi_data(spi_data), .spi_ack(b_sack),
    .spi_err(b_serr), .int_req(int_req),
    .int_addr(int_addr), .int_data(int_data),
    .int_ack(b_iack), .int_err(b_ierr),
    .wr_data(b_wr), .latch_strobe(b_stb),
    .busy(b_busy), .last_grant(b_lg)
  );

  assign o_sack = use2 ? b_sack : a_sack;
  assign o_serr = use2 ? b_serr : a_serr;
  assign o_iack = use2 ? b_iack : a_iack;
  assign o_ierr = use2 ? b_ierr : a_ierr;
  assign o_busy = use2 ? b_busy : a_busy;
  assign o_lg   = use2 ? b_lg   : a_lg;
  assign o_wr   = use2 ? b_wr   : a_wr;
  assign o_stb  = use2 ? b_stb  : a_stb;

  always #5 iclk = ~iclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int addr_index(input logic [7:0] a);
    for (int i = 0; i < 8; i++)
      if (int'(a) == valid_addrs[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(1) == 0)
      return 8'(valid_addrs[$urandom_range(7)]);
    return 8'($urandom);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, o_wr, 8'h00);
    chk({tag, "_stb"}, o_stb, 8'h00);
    chk({tag, "_busy"}, 8'(o_busy), 8'h00);
    chk({tag, "_lg"}, 8'(o_lg), 8'h00);
    chk({tag, "_sack"}, 8'(o_sack), 8'h00);
    chk({tag, "_serr"}, 8'(o_serr), 8'h00);
    chk({tag, "_iack"}, 8'(o_iack), 8'h00);
    chk({tag, "_ierr"}, 8'(o_ierr), 8'h00);
  endtask

  // One transaction granted at the current IDLE cycle.
  task automatic xact(input bit who, input logic [7:0] a,
                      input logic [7:0] d, input bit keep);
    int s, h, n, ak, idx;
    bit vld, at_ack;
    logic [7:0] oh, ew, es;
    s   = use2 ? 1 : 2;
    h   = use2 ? 3 : 1;
    idx = addr_index(a);
    vld = (idx >= 0);
    oh  = vld ? (8'd1 << idx) : 8'd0;
    n   = vld ? s + h + 2 : 2;
    ak  = vld ? 1 + s + h : 1;
    chk("idle_busy", 8'(o_busy), 8'h00);
    for (int k = 1; k <= n; k++) begin
      step();
      at_ack = (k == ak);
      ew = vld ? d : last_wr;
      es = (vld && k >= 2 && k <= 1 + s) ? oh : 8'd0;
      chk("busy", 8'(o_busy), 8'h01);
      chk("last_grant", 8'(o_lg), 8'(who));
      chk("strobe", o_stb, es);
      chk("wr_data", o_wr, ew);
      chk("spi_ack", 8'(o_sack), 8'(!who && at_ack));
      chk("int_ack", 8'(o_iack), 8'(who && at_ack));
      chk("spi_err", 8'(o_serr), 8'(!who && at_ack && !vld));
      chk("int_err", 8'(o_ierr), 8'(who && at_ack && !vld));
      if (at_ack) begin
        if (!keep) begin
          if (who) int_req = 1'b0;
          else     spi_req = 1'b0;
        end
      end else if (k < ak) begin
        if (who) begin
          int_addr = 8'($urandom);
          int_data = 8'($urandom);
        end else begin
          spi_addr = 8'($urandom);
          spi_data = 8'($urandom);
        end
      end
    end
    if (vld) last_wr = d;
    step();
  endtask

  // Pick the winner by the arbitration rules, then check it.
  task automatic check_next(input bit spi_keep, output bit who);
    logic [7:0] a, d;
    if (spi_req && int_req) who = (streak == MAXS);
    else                    who = int_req;
    if (who)          streak = 0;
    else if (int_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
    else              streak = 0;
    a = who ? int_addr : spi_addr;
    d = who ? int_data : spi_data;
    xact(who, a, d, who ? 1'b0 : spi_keep);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spi_req = 1'b0;
    int_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    streak = 0;
    last_wr = 8'h00;
    step();
  endtask

  task automatic random_run(input int iters);
    bit w;
    bit kp;
    for (int i = 0; i < iters; i++) begin
      if (!spi_req && $urandom_range(1) == 1) begin
        spi_req = 1'b1;
        spi_addr = rnd_addr();
        spi_data = 8'($urandom);
      end
      if (!int_req && $urandom_range(1) == 1) begin
        int_req = 1'b1;
        int_addr = rnd_addr();
        int_data = 8'($urandom);
      end
      if (!spi_req && !int_req) begin
        spi_req = 1'b1;
        spi_addr = rnd_addr();
        spi_data = 8'($urandom);
      end
      kp = ($urandom_range(1) == 1);
      check_next(kp, w);
      if (!w && kp) begin
        spi_addr = rnd_addr();
        spi_data = 8'($urandom);
      end
    end
    spi_req = 1'b0;
    int_req = 1'b0;
    step();
  endtask

  initial begin
    bit w;
    rst = 1'b1;
    spi_req = 1'b0;
    int_req = 1'b0;
    spi_addr = 8'h00;
    spi_data = 8'h00;
    int_addr = 8'h00;
    int_data = 8'h00;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    spi_req = 1'b1;
    spi_addr = 8'd2;
    spi_data = 8'h3C;
    step();
    step();
    chk("pre_rst_strobe", o_stb, 8'b0000_0010);
    rst = 1'b1;
    spi_req = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    rst = 1'b0;
    streak = 0;
    last_wr = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_ack", 8'(o_sack), 8'h00);
      chk("abort_idle", 8'(o_busy), 8'h00);
    end

    spi_req = 1'b1;
    spi_addr = 8'd60;
    spi_data = 8'hA5;
    check_next(1'b0, w);
    chk("single_spi_who", 8'(w), 8'h00);

    spi_req = 1'b1;
    spi_addr = 8'd1;
    spi_data = 8'h11;
    int_req = 1'b1;
    int_addr = 8'd65;
    int_data = 8'h22;
    check_next(1'b0, w);
    chk("both_first", 8'(w), 8'h00);
    check_next(1'b0, w);
    chk("both_second", 8'(w), 8'h01);

    spi_req = 1'b1;
    spi_addr = 8'd3;
    spi_data = 8'h40;
    int_req = 1'b1;
    int_addr = 8'd64;
    int_data = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      check_next(1'b1, w);
      chk("starve_seq", 8'(w), 8'(i == 4));
      spi_addr = 8'(valid_addrs[$urandom_range(7)]);
      spi_data = 8'($urandom);
    end
    spi_req = 1'b0;
    step();

    int_req = 1'b1;
    int_addr = 8'd63;
    int_data = 8'h77;
    check_next(1'b0, w);
    int_req = 1'b1;
    int_addr = 8'd10;
    int_data = 8'h88;
    check_next(1'b0, w);
    chk("invalid_who", 8'(w), 8'h01);

    random_run(30);

    do_reset();
    use2 = 1'b1;
    chk_all_zero("p2_reset");
    spi_req = 1'b1;
    spi_addr = 8'd3;
    spi_data = 8'hC3;
    check_next(1'b0, w);
    int_req = 1'b1;
    int_addr = 8'd62;
    int_data = 8'h9E;
    check_next(1'b0, w);
    random_run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
